ps2_key_encoder: RTL



---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_key_encoder_line_filter.sv | 51 +++++
 rtl/ps2_key_encoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
// Frame FSM states, prefix codes, discard list and key word fields.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  localparam int N_DISCARD = 7;
  localparam logic [7:0] PS2_DISCARD [N_DISCARD] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA,
    8'hFC, 8'hFE, 8'hFF
  };

  // Keyboard housekeeping replies that never become key events
  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DISCARD; i++)
      if (b == PS2_DISCARD[i]) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_encoder_line_filter.sv
// Synchronizes the raw PS/2 lines and glitch-filters the clock.
// Emits a one-cycle falling-edge event with the synchronized data.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fe,
  output logic o_data_s
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       r_clk_f;
  logic       r_fe;
  logic [7:0] r_cnt;
  logic       w_diff;
  logic       w_flip;

  assign w_diff = r_clk_sync[1] != r_clk_f;
  assign w_flip = w_diff &&
                  (r_cnt == 8'(FILTER_LEN - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_f    <= 1'b1;
      r_cnt      <= 8'd0;
      r_fe       <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_data};
      r_fe       <= w_flip && r_clk_f;
      if (w_flip) begin
        r_clk_f <= ~r_clk_f;
        r_cnt   <= 8'd0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  assign o_fe     = r_fe;
  assign o_data_s = r_dat_sync[1];

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 frame receiver and scan-code decoder producing the
// 11-bit {toggle, pressed, extended, code} key-event word.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 72000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          w_fe;
  logic          w_data;
  ps2_state_e    r_state;
  ps2_state_e    w_next;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_par;
  logic [TW-1:0] r_to;
  logic          w_to;
  logic          w_err;
  logic          w_done;
  logic [7:0]    r_byte;
  logic          r_byte_vld;
  logic          r_frame_err;
  logic [10:0]   r_key;
  logic          r_strobe;
  logic          r_ext;
  logic          r_rel;
  logic [2:0]    r_skip;
  logic          w_skip;
  logic          w_is_ext;
  logic          w_is_rel;
  logic          w_is_pause;
  logic          w_is_disc;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .i_clk      (clk_sys),
    .i_rst_n    (reset_n),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_fe       (w_fe),
    .o_data_s   (w_data)
  );

  // An fe in the same cycle wins over the timeout
  assign w_to = (r_state != ST_IDLE) && !w_fe &&
                (r_to == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_sys) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_done = 1'b0;
    if (w_to) begin
      w_next = ST_IDLE;
      w_err  = 1'b1;
    end else if (w_fe) begin
      case (r_state)
        ST_IDLE:   if (!w_data) w_next = ST_DATA;
        ST_DATA:   if (r_bit == 3'd7) w_next = ST_PARITY;
        ST_PARITY: w_next = ST_STOP;
        ST_STOP: begin
          w_next = ST_IDLE;
          if (w_data && ^{r_sh, r_par}) w_done = 1'b1;
          else                          w_err  = 1'b1;
        end
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_bit       <= 3'd0;
      r_sh        <= 8'd0;
      r_par       <= 1'b0;
      r_to        <= '0;
      r_byte      <= 8'd0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= w_done;
      r_frame_err <= w_err;
      if (w_done) r_byte <= r_sh;
      if (r_state == ST_IDLE || w_fe) r_to <= '0;
      else                            r_to <= r_to + 1'b1;
      if (w_fe) begin
        case (r_state)
          ST_IDLE: r_bit <= 3'd0;
          ST_DATA: begin
            r_sh  <= {w_data, r_sh[7:1]};
            r_bit <= r_bit + 3'd1;
          end
          ST_PARITY: r_par <= w_data;
          default: ;
        endcase
      end
    end
  end

  assign w_skip     = r_skip != 3'd0;
  assign w_is_ext   = !w_skip && r_byte == PS2_EXT;
  assign w_is_rel   = !w_skip && r_byte == PS2_REL;
  assign w_is_pause = !w_skip && r_byte == PS2_PAUSE;
  assign w_is_disc  = !w_skip && is_discard(r_byte);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_key    <= 11'd0;
      r_strobe <= 1'b0;
      r_ext    <= 1'b0;
      r_rel    <= 1'b0;
      r_skip   <= 3'd0;
    end else begin
      r_strobe <= 1'b0;
      if (w_err) begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end else if (r_byte_vld) begin
        unique case (1'b1)
          w_skip:     r_skip <= r_skip - 3'd1;
          w_is_ext:   r_ext  <= 1'b1;
          w_is_rel:   r_rel  <= 1'b1;
          w_is_pause: r_skip <= 3'd7;
          w_is_disc:  ;
          default: begin
            r_key[KEY_TOGGLE]  <= ~r_key[KEY_TOGGLE];
            r_key[KEY_PRESSED] <= ~r_rel;
            r_key[KEY_EXT]     <= r_ext;
            r_key[7:0]         <= r_byte;
            r_strobe           <= 1'b1;
            r_ext              <= 1'b0;
            r_rel              <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ps2_key    = r_key;
  assign key_strobe = r_strobe;
  assign frame_err  = r_frame_err;

endmodule
